ser_tx: RTL



---
 rtl/ser_pkg.sv | 12 +
 rtl/ser_tx.sv | 93 +++++++++
 2 files changed

// File: rtl/ser_pkg.sv
// Shared definitions for the single-bit serial link (ser_tx / ser_rx).
package ser_pkg;

    typedef enum logic {
        SER_ST_IDLE  = 1'b0,
        SER_ST_SHIFT = 1'b1
    } ser_state_e;

    localparam bit SER_MSB_FIRST = 1'b1;
    localparam bit SER_LSB_FIRST = 1'b0;

endpackage

// File: rtl/ser_tx.sv
// Parallel-to-serial transmitter: valid/ready word in, one registered bit per clock out,
// with a frame strobe over the word and a done pulse on its last bit.
module ser_tx
    import ser_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = SER_MSB_FIRST,
    parameter logic IDLE_VAL  = 1'b0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             data_o,
    output logic             frame_o,
    output logic             done_o
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    ser_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             data_q, data_d;
    logic             frame_q, frame_d;
    logic             done_q, done_d;
    logic             last_bit;
    logic             accept;

    // sh_q holds only the bits not yet driven; data_q is the bit currently on the line.
    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign last_bit = (state_q == SER_ST_SHIFT) && (cnt_q == LAST);
    assign ready_o  = (state_q == SER_ST_IDLE) || last_bit;
    assign accept   = valid_i && ready_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        data_d  = data_q;
        frame_d = frame_q;
        done_d  = 1'b0;
        if (accept) begin
            state_d = SER_ST_SHIFT;
            cnt_d   = '0;
            data_d  = out_bit(data_i);
            sh_d    = advance(data_i);
            frame_d = 1'b1;
        end else if (last_bit) begin
            state_d = SER_ST_IDLE;
            cnt_d   = '0;
            data_d  = IDLE_VAL;
            frame_d = 1'b0;
        end else if (state_q == SER_ST_SHIFT) begin
            cnt_d   = cnt_q + CW'(1);
            data_d  = out_bit(sh_q);
            sh_d    = advance(sh_q);
            done_d  = ((cnt_q + CW'(1)) == LAST);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= SER_ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            data_q  <= IDLE_VAL;
            frame_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            frame_q <= frame_d;
            done_q  <= done_d;
        end
    end

    assign data_o  = data_q;
    assign frame_o = frame_q;
    assign done_o  = done_q;

endmodule
